// File: rtl/fifo_pkg.sv
// Shared sizing constants for the 4-entry, 2-bit FIFO that sits behind mux21_2b.
package fifo_pkg;
    localparam int WIDTH     = 2;
    localparam int DEPTH     = 4;
    localparam int AF_THRESH = 3;
    localparam int AE_THRESH = 1;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
endpackage

// File: rtl/fifo_mem_4x2b.sv
// Register-array storage for the FIFO: one synchronous write port, one combinational read port.
module fifo_mem_4x2b
    import fifo_pkg::*;
#(
    parameter int W = WIDTH,
    parameter int D = DEPTH,
    parameter int A = $clog2(D)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [A-1:0] rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem_q [D];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_4x2b.sv
// Synchronous FIFO top: pointers, occupancy count, status flags, registered read port
// and sticky overflow/underflow error flags.
module fifo_4x2b
    import fifo_pkg::*;
#(
    parameter int W    = WIDTH,
    parameter int D    = DEPTH,
    parameter int AF_T = AF_THRESH,
    parameter int AE_T = AE_THRESH,
    parameter int PW   = $clog2(D),
    parameter int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  data_in,
    input  logic          push,
    input  logic          pop,
    output logic [W-1:0]  data_out,
    output logic          valid_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] fill_count,
    output logic          overflow_err,
    output logic          underflow_err
);

    // Handshake: a push is accepted when not full, or when full and a pop frees
    // a slot in the same cycle; a pop is accepted whenever not empty. Rejected
    // requests are dropped and only raise the matching sticky error flag.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          vout_q, vout_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_ok, rd_ok;
    logic [W-1:0]  rd_data;

    assign full         = (cnt_q == CW'(D));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CW'(AF_T));
    assign almost_empty = (cnt_q <= CW'(AE_T));

    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;

    fifo_mem_4x2b #(.W(W), .D(D), .A(PW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok && reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vout_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dout_d   = rd_data;
            vout_d   = 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (pop && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign data_out      = dout_q;
    assign valid_out     = vout_q;
    assign fill_count    = cnt_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule
